// File: rtl/rf_write_arbiter_if.sv
// Writeback request / register-file write bundle shared by rf_write_arbiter and its requesters.
interface rf_write_arbiter_if #(
  parameter int unsigned NREG = 32
);
  localparam int unsigned SW = 5;
  localparam int unsigned DW = 32;

  logic          req0_valid;
  logic          req0_ready;
  logic [SW-1:0] req0_wsel;
  logic [DW-1:0] req0_wdat;

  logic          req1_valid;
  logic          req1_ready;
  logic [SW-1:0] req1_wsel;
  logic [DW-1:0] req1_wdat;

  logic            rf_wen;
  logic [SW-1:0]   rf_wsel;
  logic [DW-1:0]   rf_wdat;
  logic            grant_id;
  logic [NREG-1:0] pending;
  logic            idle;

  // Requester / register-file side.
  modport master (
    output req0_valid, req0_wsel, req0_wdat,
    output req1_valid, req1_wsel, req1_wdat,
    input  req0_ready, req1_ready,
    input  rf_wen, rf_wsel, rf_wdat, grant_id, pending, idle
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_wsel, req0_wdat,
    input  req1_valid, req1_wsel, req1_wdat,
    output req0_ready, req1_ready,
    output rf_wen, rf_wsel, rf_wdat, grant_id, pending, idle
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter: per-requester FIFOs, round-robin drain, pending mask.
// Define RF_ARB_FIXED_PRI_EN to give requester 0 fixed priority instead of round-robin.
module rf_write_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NREG  = 32
) (
  input logic               CLK,
  input logic               RST,
  rf_write_arbiter_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = 5;
  localparam int unsigned DW = 32;

  logic [SW-1:0] wsel_q [2][DEPTH];
  logic [SW-1:0] wsel_d [2][DEPTH];
  logic [DW-1:0] wdat_q [2][DEPTH];
  logic [DW-1:0] wdat_d [2][DEPTH];
  logic [AW-1:0] wr_ptr_q [2];
  logic [AW-1:0] wr_ptr_d [2];
  logic [AW-1:0] rd_ptr_q [2];
  logic [AW-1:0] rd_ptr_d [2];
  logic [CW-1:0] count_q [2];
  logic [CW-1:0] count_d [2];

  logic          last_grant_q, last_grant_d;
  logic          rf_wen_q, rf_wen_d;
  logic [SW-1:0] rf_wsel_q, rf_wsel_d;
  logic [DW-1:0] rf_wdat_q, rf_wdat_d;
  logic          grant_id_q, grant_id_d;

  logic [1:0]      valid_c;
  logic [1:0]      ready_c;
  logic [1:0]      push_c;
  logic [1:0]      nonempty_c;
  logic [1:0]      pop_c;
  logic            src_c;
  logic [SW-1:0]   in_wsel_c [2];
  logic [DW-1:0]   in_wdat_c [2];
  logic [NREG-1:0] pending_c;
  logic            idle_c;

  assign valid_c[0]   = bus.req0_valid;
  assign valid_c[1]   = bus.req1_valid;
  assign in_wsel_c[0] = bus.req0_wsel;
  assign in_wsel_c[1] = bus.req1_wsel;
  assign in_wdat_c[0] = bus.req0_wdat;
  assign in_wdat_c[1] = bus.req1_wdat;

  // Acceptance looks at the current count only, so a full FIFO never takes a push even while popping.
  always_comb begin
    ready_c    = '0;
    push_c     = '0;
    nonempty_c = '0;
    for (int f = 0; f < 2; f++) begin
      ready_c[f]    = !RST && (count_q[f] < CW'(DEPTH));
      push_c[f]     = valid_c[f] && ready_c[f] && (in_wsel_c[f] != '0);
      nonempty_c[f] = (count_q[f] != '0);
    end
  end

  // Arbitration: single non-empty FIFO drains directly; contention alternates (or favours req0).
  always_comb begin
    last_grant_d = last_grant_q;
    src_c        = 1'b0;
    pop_c        = '0;
    if (nonempty_c == 2'b11) begin
`ifdef RF_ARB_FIXED_PRI_EN
      src_c = 1'b0;
`else
      src_c        = ~last_grant_q;
      last_grant_d = ~last_grant_q;
`endif
    end else if (nonempty_c[1]) begin
      src_c = 1'b1;
    end
    if (nonempty_c != 2'b00) begin
      pop_c = src_c ? 2'b10 : 2'b01;
    end
  end

  // FIFO storage, pointer and count next-state.
  always_comb begin
    wsel_d   = wsel_q;
    wdat_d   = wdat_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int f = 0; f < 2; f++) begin
      if (push_c[f]) begin
        wsel_d[f][wr_ptr_q[f]] = in_wsel_c[f];
        wdat_d[f][wr_ptr_q[f]] = in_wdat_c[f];
        wr_ptr_d[f]            = AW'(wr_ptr_q[f] + AW'(1));
      end
      if (pop_c[f]) begin
        rd_ptr_d[f] = AW'(rd_ptr_q[f] + AW'(1));
      end
      count_d[f] = count_q[f] + CW'(push_c[f]) - CW'(pop_c[f]);
    end
  end

  // Write-port register: loads the popped head, otherwise drops wen and holds the rest.
  always_comb begin
    rf_wen_d   = 1'b0;
    rf_wsel_d  = rf_wsel_q;
    rf_wdat_d  = rf_wdat_q;
    grant_id_d = grant_id_q;
    if (pop_c != 2'b00) begin
      rf_wen_d   = 1'b1;
      rf_wsel_d  = wsel_q[src_c][rd_ptr_q[src_c]];
      rf_wdat_d  = wdat_q[src_c][rd_ptr_q[src_c]];
      grant_id_d = src_c;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int f = 0; f < 2; f++) begin
        wr_ptr_q[f] <= '0;
        rd_ptr_q[f] <= '0;
        count_q[f]  <= '0;
      end
      last_grant_q <= 1'b1;
      rf_wen_q     <= 1'b0;
      rf_wsel_q    <= '0;
      rf_wdat_q    <= '0;
      grant_id_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      rf_wen_q     <= rf_wen_d;
      rf_wsel_q    <= rf_wsel_d;
      rf_wdat_q    <= rf_wdat_d;
      grant_id_q   <= grant_id_d;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by the counts alone.
  always_ff @(posedge CLK) begin
    wsel_q <= wsel_d;
    wdat_q <= wdat_d;
  end

  // Pending mask over occupied FIFO slots plus the in-flight write.
  always_comb begin
    pending_c = '0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (CW'(i) < count_q[f]) begin
          pending_c[wsel_q[f][AW'(rd_ptr_q[f] + AW'(i))]] = 1'b1;
        end
      end
    end
    if (rf_wen_q) begin
      pending_c[rf_wsel_q] = 1'b1;
    end
    pending_c[0] = 1'b0;
  end

  assign idle_c = (count_q[0] == '0) && (count_q[1] == '0) && !rf_wen_q;

  assign bus.req0_ready = ready_c[0];
  assign bus.req1_ready = ready_c[1];
  assign bus.rf_wen     = rf_wen_q;
  assign bus.rf_wsel    = rf_wsel_q;
  assign bus.rf_wdat    = rf_wdat_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.pending    = pending_c;
  assign bus.idle       = idle_c;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: queue-based reference model, directed and random stimulus.
module tb_rf_write_arbiter;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NREG  = 32;

  typedef struct packed {
    logic [4:0]  s;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.NREG(NREG)) bus ();

  rf_write_arbiter #(.DEPTH(DEPTH), .NREG(NREG)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: two queues, one write register, one round-robin bit.
  ent_t        q0[$];
  ent_t        q1[$];
  logic        m_wen  = 1'b0;
  logic [4:0]  m_wsel = '0;
  logic [31:0] m_wdat = '0;
  logic        m_gid  = 1'b0;
  logic        m_lg   = 1'b1;

  function automatic logic [NREG-1:0] m_pending();
    logic [NREG-1:0] p;
    p = '0;
    foreach (q0[i]) p[q0[i].s] = 1'b1;
    foreach (q1[i]) p[q1[i].s] = 1'b1;
    if (m_wen) p[m_wsel] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  always @(posedge clk) begin
    int   s0, s1;
    bit   has_pop, src;
    ent_t e;
    if (rst) begin
      q0.delete();
      q1.delete();
      m_wen = 1'b0; m_wsel = '0; m_wdat = '0; m_gid = 1'b0; m_lg = 1'b1;
    end else begin
      s0 = q0.size();
      s1 = q1.size();
      has_pop = (s0 > 0) || (s1 > 0);
      src = 1'b0;
      if (s0 > 0 && s1 > 0) begin
`ifdef RF_ARB_FIXED_PRI_EN
        src = 1'b0;
`else
        src  = ~m_lg;
        m_lg = src;
`endif
      end else if (s1 > 0) begin
        src = 1'b1;
      end
      if (has_pop) begin
        e = src ? q1.pop_front() : q0.pop_front();
        m_wen = 1'b1; m_wsel = e.s; m_wdat = e.d; m_gid = src;
      end else begin
        m_wen = 1'b0;
      end
      if (bus.req0_valid && s0 < int'(DEPTH) && bus.req0_wsel != 5'd0)
        q0.push_back('{s: bus.req0_wsel, d: bus.req0_wdat});
      if (bus.req1_valid && s1 < int'(DEPTH) && bus.req1_wsel != 5'd0)
        q1.push_back('{s: bus.req1_wsel, d: bus.req1_wdat});
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rf_wen",     64'(bus.rf_wen),     64'(m_wen));
      chk("rf_wsel",    64'(bus.rf_wsel),    64'(m_wsel));
      chk("rf_wdat",    64'(bus.rf_wdat),    64'(m_wdat));
      chk("grant_id",   64'(bus.grant_id),   64'(m_gid));
      chk("req0_ready", 64'(bus.req0_ready), 64'(!rst && q0.size() < int'(DEPTH)));
      chk("req1_ready", 64'(bus.req1_ready), 64'(!rst && q1.size() < int'(DEPTH)));
      chk("pending",    64'(bus.pending),    64'(m_pending()));
      chk("idle",       64'(bus.idle),       64'(q0.size() == 0 && q1.size() == 0 && !m_wen));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v0, input logic [4:0] s0, input logic [31:0] d0,
                       input bit v1, input logic [4:0] s1, input logic [31:0] d1);
    bus.req0_valid = v0; bus.req0_wsel = s0; bus.req0_wdat = d0;
    bus.req1_valid = v1; bus.req1_wsel = s1; bus.req1_wdat = d1;
  endtask

  task automatic idle_in();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while (!bus.idle && i < 100) begin
      tick();
      i++;
    end
    chk(name, 64'(bus.idle), 64'd1);
  endtask

  initial begin
    logic [4:0] got_sel[$];
    logic       got_gid[$];
    int         exp_sel[6];
    int         exp_gid[6];
    int         pulses;
    logic [NREG-1:0] pm;

`ifdef RF_ARB_FIXED_PRI_EN
    exp_sel = '{1, 2, 3, 11, 12, 13};
    exp_gid = '{0, 0, 0, 1, 1, 1};
`else
    exp_sel = '{1, 11, 2, 12, 3, 13};
    exp_gid = '{0, 1, 0, 1, 0, 1};
`endif

    // Reset state
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_ready0", 64'(bus.req0_ready), 64'd0);
    chk("rst_ready1", 64'(bus.req1_ready), 64'd0);
    chk("rst_wen",    64'(bus.rf_wen),     64'd0);
    chk("rst_wsel",   64'(bus.rf_wsel),    64'd0);
    chk("rst_gid",    64'(bus.grant_id),   64'd0);
    chk("rst_idle",   64'(bus.idle),       64'd1);
    rst = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("post_rst_ready0", 64'(bus.req0_ready), 64'd1);

    // Single write latency
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    tick();
    idle_in();
    pm = bus.pending;
    chk("single_pend_N",  64'(pm[5]), 64'd1);
    chk("single_wen_N",   64'(bus.rf_wen), 64'd0);
    tick();
    pm = bus.pending;
    chk("single_wen",     64'(bus.rf_wen),   64'd1);
    chk("single_wsel",    64'(bus.rf_wsel),  64'd5);
    chk("single_wdat",    64'(bus.rf_wdat),  64'hDEADBEEF);
    chk("single_gid",     64'(bus.grant_id), 64'd0);
    chk("single_pend_N1", 64'(pm[5]), 64'd1);
    tick();
    chk("single_wen_off", 64'(bus.rf_wen),  64'd0);
    chk("single_pend_0",  64'(bus.pending), 64'd0);
    chk("single_idle",    64'(bus.idle),    64'd1);

    // Contention ordering
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'(1 + k), 32'h100 + 32'(k), 1'b1, 5'(11 + k), 32'h200 + 32'(k));
      tick();
      if (bus.rf_wen) begin got_sel.push_back(bus.rf_wsel); got_gid.push_back(bus.grant_id); end
    end
    idle_in();
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.rf_wen) begin got_sel.push_back(bus.rf_wsel); got_gid.push_back(bus.grant_id); end
    end
    chk("cont_count", 64'(got_sel.size()), 64'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < got_sel.size()) begin
        chk("cont_wsel", 64'(got_sel[k]), 64'(exp_sel[k]));
        chk("cont_gid",  64'(got_gid[k]), 64'(exp_gid[k]));
      end
    end

    // r0 write is swallowed
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
    tick();
    idle_in();
    chk("r0_pend", 64'(bus.pending), 64'd0);
    chk("r0_idle", 64'(bus.idle),    64'd1);
    tick();
    chk("r0_wen",  64'(bus.rf_wen),  64'd0);

    // Reset mid-operation
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'(20 + k), 32'h300 + 32'(k), 1'b1, 5'(24 + k), 32'h400 + 32'(k));
      tick();
    end
    idle_in();
    rst = 1'b1;
    #1;
    chk("mid_rst_ready0", 64'(bus.req0_ready), 64'd0);
    chk("mid_rst_ready1", 64'(bus.req1_ready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_wen",    64'(bus.rf_wen),     64'd0);
    chk("mid_rst_pend",   64'(bus.pending),    64'd0);
    chk("mid_rst_idle",   64'(bus.idle),       64'd1);
    chk("mid_rst_ready0", 64'(bus.req0_ready), 64'd1);
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    tick();
    idle_in();
    tick();
    chk("mid_rst_first_gid",  64'(bus.grant_id), 64'd0);
    chk("mid_rst_first_wsel", 64'(bus.rf_wsel),  64'd3);
    drain("mid_rst_drain");

    // Same-register race
    pulse_reset();
    drive(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
    tick();
    idle_in();
    pm = bus.pending;
    chk("race_pend_a", 64'(pm[7]), 64'd1);
    tick();
    pm = bus.pending;
    chk("race_wdat_a", 64'(bus.rf_wdat), 64'hA);
    chk("race_pend_b", 64'(pm[7]), 64'd1);
    tick();
    pm = bus.pending;
    chk("race_wdat_b", 64'(bus.rf_wdat), 64'hB);
    chk("race_gid_b",  64'(bus.grant_id), 64'd1);
    chk("race_pend_c", 64'(pm[7]), 64'd1);
    tick();
    pm = bus.pending;
    chk("race_pend_clr", 64'(pm[7]), 64'd0);

    // Fill: both requesters push every cycle, each FIFO drains at half rate
    pulse_reset();
    pulses = 0;
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 5'(1 + k), 32'h500 + 32'(k), 1'b1, 5'(9 + k), 32'h600 + 32'(k));
      tick();
      if (bus.rf_wen) pulses++;
    end
    idle_in();
`ifndef RF_ARB_FIXED_PRI_EN
    chk("full_ready0", 64'(bus.req0_ready), 64'd0);
    chk("full_ready1", 64'(bus.req1_ready), 64'd1);
`endif
    for (int k = 0; k < 40 && !bus.idle; k++) begin
      tick();
      if (bus.rf_wen) pulses++;
    end
`ifndef RF_ARB_FIXED_PRI_EN
    chk("full_total_writes", 64'(pulses), 64'd13);
`endif
    chk("full_idle", 64'(bus.idle), 64'd1);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), $urandom);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    idle_in();
    drain("rand_drain");

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
